// File: rtl/spi_slave.sv
// SPI slave front end: deserialises SS_n-framed MOSI commands into 10-bit words and
// serialises 8-bit RAM read data on MISO. Define SPI_MISO_REG_EN to drive MISO from a flop.
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  output logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [9:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rd_addr_flag_q, rd_addr_flag_d;
  logic       tx_done_q, tx_done_d;
  logic       in_word;
  logic       tx_active;

  assign in_word   = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
  assign tx_active = (state_q == READ_DATA) && tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_done_q      <= tx_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_flag_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_done_d      = tx_done_q;
    if (SS_n) begin
      bit_cnt_d  = '0;
      tx_shift_d = '0;
      tx_done_d  = 1'b0;
    end else begin
      // The counter saturates at 10 so trailing bits in a long frame are ignored.
      if (in_word && (bit_cnt_q < 4'd10)) begin
        rx_shift_d = {rx_shift_q[8:0], MOSI};
        bit_cnt_d  = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd9) begin
          rx_data_d  = {rx_shift_q[8:0], MOSI};
          rx_valid_d = 1'b1;
          if (state_q == READ_ADD)  rd_addr_flag_d = 1'b1;
          if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
        end
      end
      // Zero-fill on shift leaves MISO low once all eight bits have gone out.
      if ((state_q == READ_DATA) && (bit_cnt_q == 4'd10)) begin
        if (tx_done_q) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end else if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_done_d  = 1'b1;
        end
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_MISO_REG_EN
  logic miso_q, miso_d;

  always_comb begin
    miso_d = 1'b0;
    if (!SS_n && tx_active) miso_d = tx_shift_q[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_q <= 1'b0;
    else        miso_q <= miso_d;
  end

  assign MISO = miso_q;
`else
  assign MISO = tx_active && tx_shift_q[7];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: random frames checked against a frame-level model of
// command decoding, read-address flag routing and MISO serialisation.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       MISO;

`ifdef SPI_MISO_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic       m_flag;
  logic [9:0] m_rx;
  int         exp_pulses;
  logic       exp_miso[$];

  int         obs_pulses;
  int         obs_pulse_idx;
  logic [9:0] obs_pulse_val;
  logic       obs_miso[$];

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  // Frame-level reference: a completed read frame toggles between address and data
  // phases; only a completed data-phase read with tx_valid produces MISO bits.
  task automatic model_frame(input logic cmd, input logic [9:0] word, input int nbits,
                             input logic [7:0] txd, input int tx_start, input int tx_hold,
                             input int tail);
    int  n;
    int  first;
    logic is_rd_data;
    n = 3 + nbits + tail;
    is_rd_data = cmd && m_flag;
    exp_miso.delete();
    for (int i = 0; i < n; i++) exp_miso.push_back(1'b0);
    exp_pulses = 0;
    if (nbits == 10) begin
      exp_pulses = 1;
      m_rx = word;
      if (cmd) m_flag = !is_rd_data;
      if (is_rd_data && tx_hold > 0) begin
        first = 12 + tx_start + 1 + LAT;
        for (int j = 0; j < 8; j++)
          if (first + j < n) exp_miso[first + j] = txd[7 - j];
      end
    end
  endtask

  // Drives one frame on negedges and records outputs just before each drive.
  task automatic run_frame(input logic cmd, input logic [9:0] word, input int nbits,
                           input logic [7:0] txd, input int tx_start, input int tx_hold,
                           input int tail);
    int last;
    int k;
    last = 2 + nbits + tail;
    obs_miso.delete();
    obs_pulses    = 0;
    obs_pulse_idx = -1;
    obs_pulse_val = '0;
    tx_data       = txd;
    for (int idx = 0; idx <= last; idx++) begin
      @(negedge clk);
      obs_miso.push_back(MISO);
      if (rx_valid) begin
        obs_pulses++;
        obs_pulse_idx = idx;
        obs_pulse_val = rx_data;
      end
      MOSI     = 1'($urandom);
      tx_valid = 1'b0;
      if (idx == last) begin
        SS_n = 1'b1;
      end else begin
        SS_n = 1'b0;
        if (idx == 1) begin
          MOSI = cmd;
        end else if (idx >= 2 && idx < 2 + nbits) begin
          MOSI = word[11 - idx];
        end else if (idx >= 2 + nbits) begin
          k = idx - 2 - nbits;
          tx_valid = (k >= tx_start) && (k < tx_start + tx_hold);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    m_flag   = 1'b0;
    m_rx     = '0;
    repeat (2) @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
    total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL reset_miso: got %0b expected 0", MISO); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("[TB] FAIL reset_rx_data: got %03h expected 000", rx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int errs;
    model_frame(1'b0, 10'h0A5, 10, 8'hFF, 0, 4, 12);
    run_frame(1'b0, 10'h0A5, 10, 8'hFF, 0, 4, 12);
    total++; if (obs_pulses !== 1) begin bad++; $display("[TB] FAIL write_pulses: got %0d expected 1", obs_pulses); end
    total++; if (obs_pulse_idx !== 12) begin bad++; $display("[TB] FAIL write_pulse_cycle: got %0d expected 12", obs_pulse_idx); end
    total++; if (obs_pulse_val !== 10'h0A5) begin bad++; $display("[TB] FAIL write_data: got %03h expected 0a5", obs_pulse_val); end
    total++; if (rx_data !== 10'h0A5) begin bad++; $display("[TB] FAIL write_hold: got %03h expected 0a5", rx_data); end
    errs = 0;
    foreach (obs_miso[i]) if (obs_miso[i] !== 1'b0) errs++;
    total++; if (errs != 0) begin bad++; $display("[TB] FAIL write_miso_quiet: got %0d high cycles expected 0", errs); end
  endtask

  task automatic test_read_pair();
    logic [9:0] words[2] = '{10'h23C, 10'h300};
    int errs;
    int ones;
    for (int f = 0; f < 2; f++) begin
      model_frame(1'b1, words[f], 10, 8'hB6, 1, 5, 14);
      run_frame(1'b1, words[f], 10, 8'hB6, 1, 5, 14);
      total++; if (obs_pulses !== 1) begin bad++; $display("[TB] FAIL read_pair_pulses[%0d]: got %0d expected 1", f, obs_pulses); end
      total++; if (obs_pulse_val !== words[f]) begin bad++; $display("[TB] FAIL read_pair_data[%0d]: got %03h expected %03h", f, obs_pulse_val, words[f]); end
      errs = 0;
      ones = 0;
      for (int i = 0; i < exp_miso.size(); i++) begin
        if (obs_miso[i] !== exp_miso[i]) errs++;
        if (obs_miso[i] === 1'b1) ones++;
      end
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL read_pair_miso[%0d]: got %0d wrong cycles expected 0", f, errs); end
      total++; if (ones != ((f == 1) ? 5 : 0)) begin bad++; $display("[TB] FAIL read_pair_ones[%0d]: got %0d expected %0d", f, ones, (f == 1) ? 5 : 0); end
    end
  endtask

  task automatic test_flag_routing();
    logic       cmds[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0] word;
    logic [7:0] txd;
    int errs;
    for (int f = 0; f < 4; f++) begin
      word = 10'($urandom);
      txd  = 8'($urandom);
      model_frame(cmds[f], word, 10, txd, 2, 3, 14);
      run_frame(cmds[f], word, 10, txd, 2, 3, 14);
      total++; if (obs_pulses !== exp_pulses) begin bad++; $display("[TB] FAIL routing_pulses[%0d]: got %0d expected %0d", f, obs_pulses, exp_pulses); end
      total++; if (rx_data !== m_rx) begin bad++; $display("[TB] FAIL routing_data[%0d]: got %03h expected %03h", f, rx_data, m_rx); end
      errs = 0;
      for (int i = 0; i < exp_miso.size(); i++) if (obs_miso[i] !== exp_miso[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL routing_miso[%0d]: got %0d wrong cycles expected 0", f, errs); end
    end
  endtask

  task automatic test_abort();
    logic [9:0] word;
    logic [7:0] txd;
    int nb;
    int errs;
    for (int f = 0; f < 3; f++) begin
      word = 10'($urandom);
      txd  = 8'($urandom);
      nb   = (f == 0) ? 6 : 10;
      model_frame(1'b1, word, nb, txd, 0, 2, (nb == 10) ? 13 : 0);
      run_frame(1'b1, word, nb, txd, 0, 2, (nb == 10) ? 13 : 0);
      total++; if (obs_pulses !== exp_pulses) begin bad++; $display("[TB] FAIL abort_pulses[%0d]: got %0d expected %0d", f, obs_pulses, exp_pulses); end
      total++; if (rx_data !== m_rx) begin bad++; $display("[TB] FAIL abort_data[%0d]: got %03h expected %03h", f, rx_data, m_rx); end
      errs = 0;
      for (int i = 0; i < exp_miso.size(); i++) if (obs_miso[i] !== exp_miso[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL abort_miso[%0d]: got %0d wrong cycles expected 0", f, errs); end
    end
  endtask

  task automatic test_back_to_back();
    logic       cmd;
    logic [9:0] word;
    logic [7:0] txd;
    int nb, ts, th, tl, errs;
    for (int f = 0; f < 16; f++) begin
      cmd  = 1'($urandom);
      word = 10'($urandom);
      txd  = 8'($urandom);
      nb   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 10;
      ts   = $urandom_range(0, 3);
      th   = $urandom_range(1, 5);
      tl   = (nb == 10) ? ts + 12 : 0;
      model_frame(cmd, word, nb, txd, ts, th, tl);
      run_frame(cmd, word, nb, txd, ts, th, tl);
      total++; if (obs_pulses !== exp_pulses) begin bad++; $display("[TB] FAIL b2b_pulses[%0d]: got %0d expected %0d", f, obs_pulses, exp_pulses); end
      if (exp_pulses == 1) begin
        total++; if (obs_pulse_idx !== 12) begin bad++; $display("[TB] FAIL b2b_pulse_cycle[%0d]: got %0d expected 12", f, obs_pulse_idx); end
      end
      total++; if (rx_data !== m_rx) begin bad++; $display("[TB] FAIL b2b_data[%0d]: got %03h expected %03h", f, rx_data, m_rx); end
      errs = 0;
      for (int i = 0; i < exp_miso.size(); i++) if (obs_miso[i] !== exp_miso[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL b2b_miso[%0d]: got %0d wrong cycles expected 0", f, errs); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [9:0] word;
    word = 10'($urandom);
    @(negedge clk); SS_n = 1'b0; tx_valid = 1'b0;
    @(negedge clk); MOSI = 1'b1;
    for (int b = 9; b >= 0; b--) begin
      @(negedge clk); MOSI = word[b];
    end
    @(negedge clk);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL midword_strobe: got %0b expected 1", rx_valid); end
    total++; if (rx_data !== word) begin bad++; $display("[TB] FAIL midword_data: got %03h expected %03h", rx_data, word); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL midword_async_valid: got %0b expected 0", rx_valid); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("[TB] FAIL midword_async_data: got %03h expected 000", rx_data); end
    @(negedge clk); rst_n = 1'b1; SS_n = 1'b1;
    m_flag = 1'b0;
    m_rx   = '0;
  endtask

  task automatic test_reset_mid_tx();
    logic [9:0] word;
    logic [7:0] txd;
    int errs;
    if (!m_flag) begin
      word = 10'($urandom);
      model_frame(1'b1, word, 10, 8'h00, 0, 0, 2);
      run_frame(1'b1, word, 10, 8'h00, 0, 0, 2);
    end
    word = 10'($urandom);
    txd  = 8'($urandom) | 8'h20;
    tx_data = txd;
    @(negedge clk); SS_n = 1'b0; tx_valid = 1'b0;
    @(negedge clk); MOSI = 1'b1;
    for (int b = 9; b >= 0; b--) begin
      @(negedge clk); MOSI = word[b];
    end
    for (int k = 0; k <= 3 + LAT; k++) begin
      @(negedge clk);
      if (k >= 1 + LAT) begin
        total++;
        if (MISO !== txd[7 - (k - 1 - LAT)]) begin
          bad++; $display("[TB] FAIL midtx_bit%0d: got %0b expected %0b", 7 - (k - 1 - LAT), MISO, txd[7 - (k - 1 - LAT)]);
        end
      end
      tx_valid = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (MISO !== 1'b0) begin bad++; $display("[TB] FAIL midtx_async_miso: got %0b expected 0", MISO); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL midtx_async_valid: got %0b expected 0", rx_valid); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("[TB] FAIL midtx_async_data: got %03h expected 000", rx_data); end
    @(negedge clk); rst_n = 1'b1; SS_n = 1'b1; tx_valid = 1'b0;
    m_flag = 1'b0;
    m_rx   = '0;
    for (int f = 0; f < 2; f++) begin
      word = 10'($urandom);
      txd  = 8'($urandom) | 8'h81;
      model_frame(1'b1, word, 10, txd, 0, 3, 12);
      run_frame(1'b1, word, 10, txd, 0, 3, 12);
      total++; if (rx_data !== m_rx) begin bad++; $display("[TB] FAIL post_reset_data[%0d]: got %03h expected %03h", f, rx_data, m_rx); end
      errs = 0;
      for (int i = 0; i < exp_miso.size(); i++) if (obs_miso[i] !== exp_miso[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL post_reset_miso[%0d]: got %0d wrong cycles expected 0", f, errs); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_pair();
    test_flag_routing();
    test_abort();
    test_back_to_back();
    test_reset_mid_word();
    test_reset_mid_tx();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
